// File: rtl/max_subtract_if.sv
// Handshake bundle between the sample/max-finder side, max_subtract and the exp stage.
interface max_subtract_if #(
    parameter int DW = 32
);
    logic          start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [DW-1:0] max_in;
    logic          max_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;

    modport master (
        output start, din, din_valid, max_in, max_valid, out_ready,
        input  out_data, out_valid, out_last, done
    );

    modport slave (
        input  start, din, din_valid, max_in, max_valid, out_ready,
        output out_data, out_valid, out_last, done
    );
endinterface

// File: rtl/max_subtract.sv
// Buffers one vector of N signed samples, latches the vector max, then streams
// saturated (x_i - max) to the exp stage over a valid/ready handshake.
module max_subtract #(
    parameter int DW = 32,
    parameter int N  = 32
) (
    input  logic          clk,
    input  logic          rst,
    max_subtract_if.slave bus
);
    localparam int            AW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_MAX,
        S_EMIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [N-1:0][DW-1:0] mem_q, mem_d;
    logic [AW-1:0]        wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]        rd_idx_q, rd_idx_d;
    logic [DW-1:0]        max_q, max_d;
    logic                 max_seen_q, max_seen_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 done_q, done_d;
    logic                 load_out;
    logic [AW-1:0]        rd_sel;

    // Difference at DW+1 bits, clamped to [-2^(DW-1), 0]; sign bits pick the clamp.
    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x, input logic [DW-1:0] m);
        logic [DW:0] diff;
        diff = {x[DW-1], x} - {m[DW-1], m};
        if (!diff[DW])
            return '0;
        else if (!diff[DW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return diff[DW-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_cnt_d    = wr_cnt_q;
        rd_idx_d    = rd_idx_q;
        max_d       = max_q;
        max_seen_d  = max_seen_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        load_out    = 1'b0;
        rd_sel      = rd_idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                if (bus.din_valid) begin
                    mem_d[wr_cnt_q] = bus.din;
                    wr_cnt_d        = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = max_seen_q ? S_EMIT : S_WAIT_MAX;
                    end
                end
            end
            S_WAIT_MAX: begin
                if (max_seen_q || bus.max_valid)
                    state_d = S_EMIT;
            end
            S_EMIT: begin
                // Output register doubles as the registered buffer read.
                if (!out_valid_q) begin
                    load_out = 1'b1;
                end else if (bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rd_sel   = rd_idx_q + 1'b1;
                        rd_idx_d = rd_sel;
                        load_out = 1'b1;
                    end
                end
            end
            S_DONE: begin
                wr_cnt_d   = '0;
                rd_idx_d   = '0;
                max_seen_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // First strobe of the vector wins.
        if ((state_q == S_LOAD || state_q == S_WAIT_MAX) && bus.max_valid && !max_seen_q) begin
            max_d      = bus.max_in;
            max_seen_d = 1'b1;
        end

        if (load_out) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_sub(mem_q[rd_sel], max_q);
            out_last_d  = (rd_sel == LAST_IDX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            rd_idx_q    <= '0;
            max_q       <= '0;
            max_seen_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_idx_q    <= rd_idx_d;
            max_q       <= max_d;
            max_seen_q  <= max_seen_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Sample storage carries no reset; contents are rewritten every vector.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_max_subtract.sv
// Directed bench for max_subtract: scoreboard of clamped differences checked every cycle.
module tb_max_subtract;
    localparam int DW = 8;
    localparam int N  = 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    max_subtract_if #(.DW(DW)) bus ();
    max_subtract #(.DW(DW), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int            n_cmp = 0;
    int            n_bad = 0;
    exp_t          expq[$];
    logic [DW-1:0] got[$];

    int v1[N] = '{5, -3, 12, 0};
    int v3[N] = '{-1, 7, -20, 3};
    int v4[N] = '{-128, 10, 127, -5};
    int v5[N] = '{10, 3, -128, 0};

    function automatic int sat_model(input int x, input int m);
        int lo;
        int d;
        lo = -(1 << (DW - 1));
        d  = x - m;
        if (d > 0)  return 0;
        if (d < lo) return lo;
        return d;
    endfunction

    function automatic logic [31:0] sx(input logic [DW-1:0] v);
        return 32'($signed(v));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d", name, $signed(act), $signed(req));
        end
    endtask

    // Scoreboard process: every cycle out of reset, outputs are checked against the model.
    logic          pend_done  = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            expq.delete();
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("done", 32'(bus.done), 32'(pend_done));
            pend_done = 1'b0;
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_hold", sx(bus.out_data), sx(prev_data));
            end
            prev_stall = 1'b0;
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("out_data", sx(bus.out_data), expq[0].data);
                    check("out_last", 32'(bus.out_last), 32'(expq[0].last));
                    if (bus.out_ready) begin
                        got.push_back(bus.out_data);
                        pend_done = expq[0].last;
                        void'(expq.pop_front());
                    end else begin
                        prev_stall = 1'b1;
                        prev_data  = bus.out_data;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_vec(input int v[N], input int m);
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.data = 32'(sat_model(v[i], m));
            e.last = (i == N - 1);
            expq.push_back(e);
        end
    endtask

    task automatic load_vec(input int v[N], input int max_at, input int m,
                            input int dup_at, input int dup_m, input logic hold_start);
        bus.start = 1'b1;
        step();
        bus.start = hold_start;
        for (int i = 0; i < N; i++) begin
            bus.din       = DW'(v[i]);
            bus.din_valid = 1'b1;
            bus.max_valid = (i == max_at) || (i == dup_at);
            bus.max_in    = DW'((i == dup_at) ? dup_m : m);
            step();
        end
        bus.din_valid = 1'b0;
        bus.max_valid = 1'b0;
    endtask

    task automatic send_max(input int m);
        bus.max_valid = 1'b1;
        bus.max_in    = DW'(m);
        step();
        bus.max_valid = 1'b0;
    endtask

    // pat 0: ready always high; pat 1: ready pattern 1,0,0,1 repeating.
    task automatic wait_done(input int pat, input logic start_val);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            bus.out_ready = (pat == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            bus.start     = start_val;
            step();
            seen = bus.done;
        end
        check("done_seen", 32'(seen), 32'd1);
        bus.out_ready = 1'b1;
    endtask

    task automatic check_lits(input string tag, input int l0, input int l1, input int l2, input int l3);
        int lits[4];
        lits = '{l0, l1, l2, l3};
        check({tag, "_count"}, 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check($sformatf("%s_lit%0d", tag, i), sx(got[i]), 32'(lits[i]));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_data"},  sx(bus.out_data),   32'd0);
        check({tag, "_last"},  32'(bus.out_last),  32'd0);
        check({tag, "_done"},  32'(bus.done),      32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.max_in    = '0;
        bus.max_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        step();

        // Case 1: max arrives after load; WAIT_MAX holds until then.
        got.delete();
        push_vec(v1, 12);
        load_vec(v1, -1, 0, -1, 0, 1'b0);
        repeat (5) begin
            step();
            check("wait_max_hold", 32'(bus.out_valid), 32'd0);
        end
        send_max(12);
        check("c1_lat0", 32'(bus.out_valid), 32'd0);
        step();
        check("c1_lat1", 32'(bus.out_valid), 32'd1);
        wait_done(0, 1'b0);
        check_lits("c1", -7, -15, 0, -12);

        // Case 2: max during load; second strobe ignored; two-cycle latency.
        step();
        got.delete();
        push_vec(v1, 12);
        load_vec(v1, 1, 12, 3, 100, 1'b0);
        check("c2_lat0", 32'(bus.out_valid), 32'd0);
        step();
        check("c2_lat1", 32'(bus.out_valid), 32'd1);
        wait_done(0, 1'b0);
        check_lits("c2", -7, -15, 0, -12);

        // Case 3: backpressure.
        step();
        got.delete();
        push_vec(v3, 7);
        load_vec(v3, 0, 7, -1, 0, 1'b0);
        wait_done(1, 1'b0);
        check_lits("c3", -8, 0, -27, -4);

        // Case 4: saturation at both ends.
        step();
        got.delete();
        push_vec(v4, 127);
        load_vec(v4, 2, 127, -1, 0, 1'b0);
        wait_done(0, 1'b0);
        check_lits("c4a", -128, -117, 0, -128);
        step();
        got.delete();
        push_vec(v5, 3);
        load_vec(v5, -1, 0, -1, 0, 1'b0);
        send_max(3);
        wait_done(0, 1'b0);
        check_lits("c4b", 0, 0, -128, -3);

        // Case 5: reset mid-EMIT, then a clean vector.
        step();
        push_vec(v1, 12);
        load_vec(v1, 2, 12, -1, 0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("c5_rst");
        step();
        got.delete();
        push_vec(v1, 12);
        load_vec(v1, 2, 12, -1, 0, 1'b0);
        wait_done(0, 1'b0);
        check_lits("c5", -7, -15, 0, -12);

        // Case 6: stray start, surplus samples, start in DONE, inputs while IDLE.
        step();
        got.delete();
        push_vec(v1, 12);
        load_vec(v1, -1, 0, -1, 0, 1'b1);
        bus.din       = DW'(99);
        bus.din_valid = 1'b1;
        repeat (2) step();
        bus.din_valid = 1'b0;
        send_max(12);
        wait_done(0, 1'b1);
        step();
        bus.start = 1'b0;
        check_lits("c6", -7, -15, 0, -12);
        bus.din       = DW'(50);
        bus.din_valid = 1'b1;
        bus.max_in    = DW'(100);
        bus.max_valid = 1'b1;
        repeat (4) step();
        bus.din_valid = 1'b0;
        bus.max_valid = 1'b0;
        repeat (6) step();
        check("c6_idle_valid", 32'(bus.out_valid), 32'd0);

        // Case 7: strobes seen while idle must not pre-arm the next vector.
        got.delete();
        push_vec(v1, 12);
        load_vec(v1, -1, 0, -1, 0, 1'b0);
        step();
        check("c7_wait", 32'(bus.out_valid), 32'd0);
        send_max(12);
        wait_done(0, 1'b0);
        check_lits("c7", -7, -15, 0, -12);
        repeat (3) step();
        check("leftover_expect", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
